load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the data_memory port (A/WD/WE/RD). Turns core load/store requests
//  (byte/half/word, signed/unsigned) into word accesses on a word-wide memory.
//  Sub-word stores use a read-modify-write sequence. Sits between the MEM stage of the
//  multi-cycle core and data_memory.
// PARAMETERS
//  ADDR_W      32  byte-address width; memory word address = addr[ADDR_W-1:2]
//  BIG_ENDIAN  1   1: byte offset 0 = bits[31:24] (MIPS); 0: offset 0 = bits[7:0]
// PORTS
//  clk           in   1       single clock; all state updates on posedge
//  reset         in   1       asynchronous, active-high
//  req_valid     in   1       core request present
//  req_ready     out  1       LSU idle and able to accept; transfer on valid&&ready at posedge
//  req_we        in   1       1 = store, 0 = load
//  req_size      in   2       00 byte, 01 half, 10 word, 11 reserved
//  req_unsigned  in   1       loads: 1 zero-extend, 0 sign-extend; ignored for stores
//  req_addr      in   ADDR_W  byte address
//  req_wdata     in   32      store data, right-justified (byte in [7:0], half in [15:0])
//  resp_valid    out  1       one-cycle pulse: request finished; no backpressure
//  resp_rdata    out  32      extended load data; 0 for stores and errors
//  resp_err      out  1       misaligned address or reserved size; valid with resp_valid
//  mem_a         out  ADDR_W  word-aligned address to data_memory, {addr[ADDR_W-1:2],2'b00}
//  mem_wd        out  32      write data to data_memory
//  mem_we        out  1       write enable; data_memory writes on posedge while high
//  mem_rd        in   32      read data from data_memory (combinational from mem_a)
// BEHAVIOUR
//  Reset (async): state IDLE; mem_a=0, mem_wd=0, mem_we=0, resp_valid=0, resp_rdata=0,
//   resp_err=0, latched request cleared. req_ready=0 while reset is high.
//  req_ready = (state==IDLE) && !reset. Fields are latched at acceptance. Later req_* changes
//   are ignored until the LSU returns to IDLE.
//  FSM states: IDLE, READ, WRITE, RESP.
//   IDLE -> RESP   on accept with error (half addr[0]!=0, word addr[1:0]!=0, or size 11).
//                  No memory access and no mem_we.
//   IDLE -> READ   on accept for load or for sub-word store.
//   IDLE -> WRITE  on accept for word store.
//   READ -> RESP   for load. resp_rdata is extracted from mem_rd sampled at the end of READ.
//   READ -> WRITE  for sub-word store. Merged word = mem_rd with the selected lane replaced.
//   WRITE -> RESP  mem_we=1 for exactly this cycle; mem_a/mem_wd are stable for the whole cycle.
//   RESP -> IDLE   resp_valid=1 for exactly this cycle.
//  mem_we is high only in WRITE and never toggles within a cycle. mem_a is driven from the
//   latched address in READ and WRITE.
//  Latency from the accepting posedge to the resp_valid cycle:
//   error = 1, load = 2, word store = 2, sub-word store = 3.
//  Lane select (BIG_ENDIAN=1): byte lane = 3-addr[1:0]; half lane = addr[1] ? [15:0] : [31:16].
//  Load extension: sign from the lane MSB unless req_unsigned. Word loads pass through unchanged.
//  Reset mid-operation: mem_we drops as soon as reset asserts. Any in-flight RMW is abandoned
//   and no partial write occurs after reset. No resp_valid is issued for the aborted request.
// STRUCTURE
//  lsu_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state enum, lane helper constants.
//  Sub-module lsu_lane_align (combinational): extract+extend for loads, lane merge for stores.
//   Shared by the READ->RESP and READ->WRITE paths.
//  The top level holds the FSM, the request latch and the registered response outputs.
// TESTING (bench instantiates data_memory as the target)
//  1 sw addr 0x10 wdata 0xDEADBEEF -> one mem_we cycle at mem_a 0x10, resp 2 cycles later.
//    Then lw 0x10 -> resp_rdata 0xDEADBEEF, resp_err 0.
//  2 mem[0x10]=0x12F45678. lb 0x11 -> 0xFFFFFFF4; lbu 0x11 -> 0x000000F4; lhu 0x12 -> 0x00005678.
//  3 mem[0x10]=0xDEADBEEF. sh 0x12 wdata 0x0000ABCD -> READ then WRITE, mem_wd 0xDEADABCD.
//    Resp 3 cycles after accept; exactly one mem_we pulse.
//  4 lw 0x13, and sh 0x11 -> resp_err=1, resp_rdata 0, mem_we never high, resp 1 cycle after accept.
//  5 req_valid held high for 2 requests -> req_ready low from accept through RESP.
//    Second request accepted the cycle after resp_valid; no request lost or duplicated.
//  6 sb 0x10 wdata 0x55, reset asserted during WRITE -> mem_we low before the next posedge.
//    Outputs return to reset values and no resp_valid; req_ready=1 after reset release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and lane geometry.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    function automatic logic access_err(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: access_err = 1'b0;
            SZ_HALF: access_err = offset[0];
            SZ_WORD: access_err = |offset;
            default: access_err = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane steering between a memory word and the core: extract/extend for loads,
// lane replacement for read-modify-write stores.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [31:0] rd_word,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [1:0]        byte_lane;
    logic              half_hi;
    logic [BYTE_W-1:0] sel_byte;
    logic [HALF_W-1:0] sel_half;

    always_comb begin
        byte_lane = BIG_ENDIAN ? (2'd3 - offset) : offset;
        half_hi   = BIG_ENDIAN ? ~offset[1] : offset[1];
        sel_byte  = rd_word[{byte_lane, 3'b000} +: BYTE_W];
        sel_half  = half_hi ? rd_word[31:16] : rd_word[15:0];
        load_data = rd_word;
        merged    = rd_word;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{~is_unsigned & sel_byte[BYTE_W-1]}}, sel_byte};
                merged[{byte_lane, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
            end
            SZ_HALF: begin
                load_data = {{16{~is_unsigned & sel_half[HALF_W-1]}}, sel_half};
                merged[{half_hi, 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
            end
            default: begin
                load_data = rd_word;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word core requests into word accesses on data_memory,
// with read-modify-write for sub-word stores and registered response outputs.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_wd,
    output logic              mem_we,
    input  logic [31:0]       mem_rd
);

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [31:0]       mem_wd_q, mem_wd_d;
    logic              mem_we_q, mem_we_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic              accept;
    logic [31:0]       load_data;
    logic [31:0]       merged;

    lsu_lane_align #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_align (
        .rd_word     (mem_rd),
        .size        (size_q),
        .is_unsigned (uns_q),
        .offset      (off_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    assign req_ready = (state_q == ST_IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        mem_a_d      = mem_a_q;
        mem_wd_d     = mem_wd_q;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    off_d   = req_addr[1:0];
                    wdata_d = req_wdata;
                    if (access_err(req_size, req_addr[1:0])) begin
                        state_d    = ST_RESP;
                        resp_err_d = 1'b1;
                    end else begin
                        mem_a_d  = {req_addr[ADDR_W-1:2], 2'b00};
                        mem_wd_d = req_wdata;
                        state_d  = (req_we && req_size == SZ_WORD) ? ST_WRITE : ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (we_q) begin
                    mem_wd_d = merged;
                    state_d  = ST_WRITE;
                end else begin
                    resp_rdata_d = load_data;
                    state_d      = ST_RESP;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            default:  state_d = ST_IDLE;
        endcase
        // Strobes are registered from the next state so they are glitch-free for the whole cycle.
        mem_we_d     = (state_d == ST_WRITE);
        resp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            size_q       <= SZ_BYTE;
            uns_q        <= 1'b0;
            off_q        <= '0;
            wdata_q      <= '0;
            mem_a_q      <= '0;
            mem_wd_q     <= '0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            mem_a_q      <= mem_a_d;
            mem_wd_q     <= mem_wd_d;
            mem_we_q     <= mem_we_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign mem_a      = mem_a_q;
    assign mem_wd     = mem_wd_q;
    assign mem_we     = mem_we_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit driving a small word-wide memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:63];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    load_store_unit #(
        .ADDR_W     (32),
        .BIG_ENDIAN (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_a        (mem_a),
        .mem_wd       (mem_wd),
        .mem_we       (mem_we),
        .mem_rd       (mem_rd)
    );

    assign mem_rd = mem[mem_a[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    // Issue one request; report latency (cycles after accept), response and write activity.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output int we_cnt, output logic [31:0] we_a, output logic [31:0] we_wd);
        wait_ready();
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = -1; rdata = '0; err = 1'b0; we_cnt = 0; we_a = '0; we_wd = '0;
        for (int c = 1; c <= 8; c++) begin
            if (mem_we) begin
                we_cnt++;
                we_a  = mem_a;
                we_wd = mem_wd;
            end
            if (resp_valid) begin
                lat   = c;
                rdata = resp_rdata;
                err   = resp_err;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin : main
        int          lat, we_cnt;
        logic [31:0] rd, wa, wwd;
        logic        er;
        int          acc, resps, cyc, ready_bad, guard;
        int          acc_cyc  [0:1];
        int          resp_cyc [0:1];
        logic [31:0] rdv      [0:1];
        logic        will_accept;
        logic        saw_resp;

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        @(negedge clk); reset = 1'b0; #1;
        chk("rel_ready", 32'(req_ready), 32'd1);

        // Word store then word load
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er, we_cnt, wa, wwd);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_we_cnt", 32'(we_cnt), 32'd1);
        chk("sw_mem_a", wa, 32'h10);
        chk("sw_mem_wd", wwd, 32'hDEADBEEF);
        chk("sw_rdata", rd, 32'h0);
        chk("sw_err", 32'(er), 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, we_cnt, wa, wwd);
        chk("lw_lat", 32'(lat), 32'd2);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_err", 32'(er), 32'd0);
        chk("lw_we_cnt", 32'(we_cnt), 32'd0);

        // Sub-word loads, big-endian lanes
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h12F45678, lat, rd, er, we_cnt, wa, wwd);
        chk("sw2_lat", 32'(lat), 32'd2);
        do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat, rd, er, we_cnt, wa, wwd);
        chk("lb_11", rd, 32'hFFFFFFF4);
        chk("lb_lat", 32'(lat), 32'd2);
        do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, rd, er, we_cnt, wa, wwd);
        chk("lbu_11", rd, 32'h000000F4);
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, rd, er, we_cnt, wa, wwd);
        chk("lhu_12", rd, 32'h00005678);
        do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, lat, rd, er, we_cnt, wa, wwd);
        chk("lh_10", rd, 32'h000012F4);
        do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, rd, er, we_cnt, wa, wwd);
        chk("lb_13", rd, 32'h00000078);

        // Sub-word stores via read-modify-write
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er, we_cnt, wa, wwd);
        do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000ABCD, lat, rd, er, we_cnt, wa, wwd);
        chk("sh_lat", 32'(lat), 32'd3);
        chk("sh_we_cnt", 32'(we_cnt), 32'd1);
        chk("sh_mem_wd", wwd, 32'hDEADABCD);
        chk("sh_mem_a", wa, 32'h10);
        chk("sh_mem", mem[4], 32'hDEADABCD);
        do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFFFF11, lat, rd, er, we_cnt, wa, wwd);
        chk("sb_lat", 32'(lat), 32'd3);
        chk("sb_mem_wd", wwd, 32'hDEADAB11);
        chk("sb_mem", mem[4], 32'hDEADAB11);

        // Error cases
        do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, lat, rd, er, we_cnt, wa, wwd);
        chk("lw13_err", 32'(er), 32'd1);
        chk("lw13_rdata", rd, 32'h0);
        chk("lw13_lat", 32'(lat), 32'd1);
        do_req(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000FFFF, lat, rd, er, we_cnt, wa, wwd);
        chk("sh11_err", 32'(er), 32'd1);
        chk("sh11_lat", 32'(lat), 32'd1);
        chk("sh11_we_cnt", 32'(we_cnt), 32'd0);
        chk("sh11_mem", mem[4], 32'hDEADAB11);
        do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, rd, er, we_cnt, wa, wwd);
        chk("rsvd_err", 32'(er), 32'd1);
        chk("rsvd_rdata", rd, 32'h0);

        // Back-to-back requests with req_valid held high
        wait_ready();
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
        req_valid = 1'b1;
        acc = 0; resps = 0; cyc = 0; ready_bad = 0;
        acc_cyc[0] = -1; acc_cyc[1] = -1; resp_cyc[0] = -1; resp_cyc[1] = -1;
        rdv[0] = '0; rdv[1] = '0;
        for (int k = 0; k < 20 && resps < 2; k++) begin
            will_accept = req_ready && req_valid;
            if (will_accept && acc < 2) begin
                acc_cyc[acc] = cyc + 1;
            end
            if (will_accept) acc++;
            @(posedge clk); cyc++; #1;
            if (will_accept) begin
                if (acc == 1) begin
                    req_size = 2'b00; req_addr = 32'h10;
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (resp_valid) begin
                if (resps < 2) begin
                    resp_cyc[resps] = cyc;
                    rdv[resps] = resp_rdata;
                end
                resps++;
            end
            if (req_ready && (acc > resps || resp_valid)) ready_bad++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (resp_valid) resps++;
        end
        chk("b2b_accepts", 32'(acc), 32'd2);
        chk("b2b_resps", 32'(resps), 32'd2);
        chk("b2b_ready_busy", 32'(ready_bad), 32'd0);
        chk("b2b_resp1_lat", 32'(resp_cyc[0] - acc_cyc[0]), 32'd1);
        chk("b2b_acc2_gap", 32'(acc_cyc[1] - resp_cyc[0]), 32'd2);
        chk("b2b_rdata0", rdv[0], 32'hDEADAB11);
        chk("b2b_rdata1", rdv[1], 32'hFFFFFFDE);

        // Reset during the write phase of a byte store
        wait_ready();
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h10;
        req_wdata = 32'h00000055; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        guard = 0;
        while (!mem_we && guard < 6) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("rmw_reached_write", 32'(mem_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_mem_we", 32'(mem_we), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd0);
        chk("abort_mem_a", mem_a, 32'd0);
        chk("abort_mem_wd", mem_wd, 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        saw_resp = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (resp_valid) saw_resp = 1'b1;
        end
        @(negedge clk); reset = 1'b0; #1;
        chk("abort_ready_after", 32'(req_ready), 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
            if (resp_valid) saw_resp = 1'b1;
        end
        chk("abort_no_resp", 32'(saw_resp), 32'd0);
        chk("abort_mem_intact", mem[4], 32'hDEADAB11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
